fip_32_cramer_sched: RTL
========================

Name: fip_32_cramer_sched

Overview:
- Sequencer for one shared fip_32_3b3_det pipeline that solves the 3x3 Cramer's-rule system used by ray/triangle intersection.
- Accepts one job: column vectors c0, c1, c2 and right-hand side b.
- Issues four matrices to the det pipeline on consecutive cycles: A=[c0 c1 c2], Ax=[b c1 c2], Ay=[c0 b c2], Az=[c0 c1 b].
- Collects the four determinants and presents them together on a valid/ready output, with a singularity flag. Sits between the ray setup stage and the barycentric divide stage.

Parameters:
- FRA_BITS, 16, fractional bits of the Q-format. Passed to the det pipeline's multipliers.
- SING_EPS, 32'sd0, singularity threshold. |det(A)| <= SING_EPS raises o_singular. Non-negative.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  job present.
- o_ready  out  1  block can accept a job.
- i_cols  in  signed 32 [0:2][0:2]  i_cols[k] is column vector ck.
- i_rhs  in  signed 32 [0:2]  vector b.
- o_valid  out  1  results present.
- i_ready  in  1  consumer accepts results.
- o_det  out  signed 32  det(A).
- o_det_x  out  signed 32  det(Ax).
- o_det_y  out  signed 32  det(Ay).
- o_det_z  out  signed 32  det(Az).
- o_singular  out  1  |o_det| <= SING_EPS, valid with o_valid.

Behaviour:
- Reset: state=IDLE, all counters 0, o_valid=0, o_singular=0, result registers 0. In-flight det results are discarded.
- The det instance's i_rstn is tied to ~i_rst. Its valid bits may be stale after reset. The controller ignores det o_valid outside ISSUE/DRAIN.
- Job handshake: a job transfers on a rising edge E0 where i_valid && o_ready. o_ready = (state==IDLE).
- On the transfer, i_cols and i_rhs are copied to a job register. Inputs are don't-care afterwards.
- States:
  - IDLE: waits for transfer, then goes to ISSUE with issue_idx=0.
  - ISSUE: det i_en=1 and the det matrix is selected by issue_idx (0:A, 1:Ax, 2:Ay, 3:Az). Columns are fed as det rows; det is transpose-invariant. issue_idx increments each edge. After the edge sampling idx 3, go to DRAIN.
  - DRAIN: det i_en=0. Wait until all 4 results are captured, then go to DONE.
  - DONE: o_valid=1 and outputs held stable. On i_valid-independent i_ready=1 at an edge, go to IDLE.
- Capture: on each edge where state is ISSUE or DRAIN and det o_valid=1, store o_det into slot res_idx (0..3) and increment res_idx.
- |o_det| for o_singular is computed when slot 0 is captured and registered. abs(FIP_MIN) saturates to FIP_MAX.
- Timing: issue edges are E1..E4; det latency is 2; captures occur at E3..E6; o_valid rises after E6. Acceptance-to-o_valid is exactly 6 edges.
- Minimum job interval is 8 edges (output accepted at E7 at the earliest, next job at E8).
- i_ready held high while o_valid is high gives one result transfer, then IDLE. i_ready low holds DONE indefinitely and the outputs do not change.
- i_valid during ISSUE/DRAIN/DONE is ignored (o_ready=0). No job is lost, because the producer must hold it.
- Arithmetic: products are Q(32-FRA_BITS).FRA_BITS, truncated, with wrap on overflow as in the det pipeline. The scheduler applies no saturation beyond the abs computation.
- Async reset mid-job returns to IDLE on assertion. The first post-reset job behaves exactly as from a cold start.

Decomposition:
- Shared package fip_pkg:
  - FIP_MIN / FIP_MAX constants.
  - typedef fip_t (signed 32).
  - typedef fip_vec3_t (fip_t [0:2]).
  - typedef fip_mat3_t (fip_t [0:2][0:2]).
  - enum cramer_state_t {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module: one instance of fip_32_3b3_det. The matrix select mux stays inline.

Test Plan:
- Identity A (1.0=32'h00010000 on diagonal), b=(2.0,3.0,4.0) -> o_det=0x00010000, det_x=0x00020000, det_y=0x00030000, det_z=0x00040000, o_singular=0, o_valid exactly 6 edges after acceptance.
- c0=c1=(1.0,2.0,3.0), c2=(0,0,1.0), b arbitrary -> o_det=0, o_singular=1. With SING_EPS=16, det(A)=10 LSB also gives o_singular=1.
- Hold i_ready=0 for 20 cycles after o_valid -> outputs constant and o_ready=0. A job driven meanwhile is not accepted; it transfers on the edge after the result handshake.
- Back-to-back jobs with i_valid and i_ready tied high -> accepts at E0 and E8, and two correct result sets in order.
- Assert i_rst at E3 of a job, release at E5, then submit a new job -> o_ready=1 immediately after release, no spurious o_valid, and the new job's results are exact.
- A=[[2,0,0],[0,2,0],[0,0,2]] (Q16) and b=(-1.0,0,1.0) -> o_det=0x00080000, det_x=0xFFFC0000, det_y=0, det_z=0x00040000.

Source files
------------

// File: rtl/fip_pkg.sv
// Shared fixed-point types, constants and helpers for the Cramer's-rule solver.
package fip_pkg;

  localparam int FIP_W = 32;

  typedef logic signed [FIP_W-1:0] fip_t;
  typedef fip_t [0:2]              fip_vec3_t;
  typedef fip_t [0:2][0:2]         fip_mat3_t;

  localparam fip_t FIP_MIN = 32'sh8000_0000;
  localparam fip_t FIP_MAX = 32'sh7fff_ffff;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cramer_state_t;

  // Q-format multiply: full-width product, arithmetic shift (truncates toward
  // minus infinity), then wrap to 32 bits.
  function automatic fip_t fip_mul(input fip_t a, input fip_t b, input int unsigned fra);
    logic signed [2*FIP_W-1:0] wa;
    logic signed [2*FIP_W-1:0] wb;
    logic signed [2*FIP_W-1:0] prod;
    wa   = a;
    wb   = b;
    prod = wa * wb;
    return fip_t'(prod >>> fra);
  endfunction

  // Absolute value; the most negative code has no positive twin, so it saturates.
  function automatic fip_t fip_abs(input fip_t a);
    if (a == FIP_MIN) return FIP_MAX;
    return (a < 0) ? -a : a;
  endfunction

endpackage

// File: rtl/fip_32_3b3_det.sv
// Two-stage 3x3 determinant pipeline: stage 1 forms the row-0 cofactor minors,
// stage 2 combines them with row 0. Result appears two edges after i_en.
module fip_32_3b3_det
  import fip_pkg::*;
#(
  parameter int unsigned FRA_BITS = 16
) (
  input  logic      i_clk,
  input  logic      i_rstn,
  input  logic      i_en,
  input  fip_mat3_t i_mat,
  output logic      o_valid,
  output fip_t      o_det
);

  fip_vec3_t row0_reg;
  fip_vec3_t minor_reg;
  fip_vec3_t minor_next;
  logic      valid1_reg;

  // Minor gi drops column gi; ca/cb are the two remaining columns in order.
  for (genvar gi = 0; gi < 3; gi++) begin : g_minor
    localparam int CA = (gi == 0) ? 1 : 0;
    localparam int CB = (gi == 2) ? 1 : 2;
    assign minor_next[gi] = fip_mul(i_mat[1][CA], i_mat[2][CB], FRA_BITS)
                          - fip_mul(i_mat[1][CB], i_mat[2][CA], FRA_BITS);
  end

  // Stage 1: latch row 0 and the three minors.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid1_reg <= 1'b0;
      row0_reg   <= '0;
      minor_reg  <= '0;
    end else begin
      valid1_reg <= i_en;
      if (i_en) begin
        row0_reg  <= i_mat[0];
        minor_reg <= minor_next;
      end
    end
  end

  // Stage 2: cofactor expansion along row 0.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_det   <= '0;
    end else begin
      o_valid <= valid1_reg;
      if (valid1_reg) begin
        o_det <= fip_mul(row0_reg[0], minor_reg[0], FRA_BITS)
               - fip_mul(row0_reg[1], minor_reg[1], FRA_BITS)
               + fip_mul(row0_reg[2], minor_reg[2], FRA_BITS);
      end
    end
  end

endmodule

// File: rtl/fip_32_cramer_sched.sv
// Drives one shared determinant pipeline with A, Ax, Ay, Az for a single job
// and presents the four determinants plus a singularity flag on valid/ready.
module fip_32_cramer_sched
  import fip_pkg::*;
#(
  parameter int unsigned FRA_BITS = 16,
  parameter fip_t        SING_EPS = 32'sd0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_valid,
  output logic      o_ready,
  input  fip_mat3_t i_cols,
  input  fip_vec3_t i_rhs,
  output logic      o_valid,
  input  logic      i_ready,
  output fip_t      o_det,
  output fip_t      o_det_x,
  output fip_t      o_det_y,
  output fip_t      o_det_z,
  output logic      o_singular
);

  cramer_state_t state_reg;
  logic [1:0]    issue_idx_reg;
  logic [1:0]    res_idx_reg;
  fip_mat3_t     job_cols_reg;
  fip_vec3_t     job_rhs_reg;
  fip_t          res_reg [0:3];
  fip_t          det_abs_reg;
  logic          o_valid_reg;
  logic          o_singular_reg;

  fip_mat3_t     det_mat;
  logic          det_en;
  logic          det_valid;
  fip_t          det_out;
  logic          capture;

  // Column k is replaced by b when issue_idx == k+1; columns go in as rows.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sel
    assign det_mat[gi] = (issue_idx_reg == 2'(gi + 1)) ? job_rhs_reg : job_cols_reg[gi];
  end

  assign det_en  = (state_reg == ISSUE);
  assign capture = ((state_reg == ISSUE) || (state_reg == DRAIN)) && det_valid;

  fip_32_3b3_det #(
    .FRA_BITS(FRA_BITS)
  ) u_det (
    .i_clk  (i_clk),
    .i_rstn (~i_rst),
    .i_en   (det_en),
    .i_mat  (det_mat),
    .o_valid(det_valid),
    .o_det  (det_out)
  );

  // Controller FSM: accept, issue four matrices, collect four results, hand off.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      issue_idx_reg  <= '0;
      res_idx_reg    <= '0;
      job_cols_reg   <= '0;
      job_rhs_reg    <= '0;
      det_abs_reg    <= '0;
      o_valid_reg    <= 1'b0;
      o_singular_reg <= 1'b0;
      for (int k = 0; k < 4; k++) res_reg[k] <= '0;
    end else begin
      if (capture) begin
        res_reg[res_idx_reg] <= det_out;
        res_idx_reg          <= res_idx_reg + 2'd1;
        if (res_idx_reg == 2'd0) det_abs_reg <= fip_abs(det_out);
      end
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            job_cols_reg  <= i_cols;
            job_rhs_reg   <= i_rhs;
            issue_idx_reg <= '0;
            res_idx_reg   <= '0;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          issue_idx_reg <= issue_idx_reg + 2'd1;
          if (issue_idx_reg == 2'd3) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (capture && (res_idx_reg == 2'd3)) begin
            state_reg      <= DONE;
            o_valid_reg    <= 1'b1;
            o_singular_reg <= (det_abs_reg <= SING_EPS);
          end
        end
        DONE: begin
          if (i_ready) begin
            state_reg      <= IDLE;
            o_valid_reg    <= 1'b0;
            o_singular_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_ready    = (state_reg == IDLE);
  assign o_valid    = o_valid_reg;
  assign o_singular = o_singular_reg;
  assign o_det      = res_reg[0];
  assign o_det_x    = res_reg[1];
  assign o_det_y    = res_reg[2];
  assign o_det_z    = res_reg[3];

endmodule
